// File: rtl/aha_sif_sram_bridge.sv
// aha_sif_sram_bridge: SIF write/read channels onto one single-port 64-bit SRAM,
// with a collision write buffer, read-side byte forwarding and fixed 2-cycle read latency.
module aha_sif_sram_bridge #(
  parameter int AW = 10,
  parameter int WB_DEPTH = 4,
  localparam int PW = $clog2(WB_DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic [31:0]   SIF_WR_ADDR,
  input  logic          SIF_WR_EN,
  input  logic [7:0]    SIF_WR_STRB,
  input  logic [63:0]   SIF_WR_DATA,
  input  logic [31:0]   SIF_RD_ADDR,
  input  logic          SIF_RD_EN,
  output logic [63:0]   SIF_RD_DATA,
  output logic          SIF_RD_VALID,
  output logic          SRAM_CEN,
  output logic          SRAM_WEN,
  output logic [AW-1:0] SRAM_ADDR,
  output logic [7:0]    SRAM_WMASK,
  output logic [63:0]   SRAM_WDATA,
  input  logic [63:0]   SRAM_RDATA,
  output logic [LW-1:0] WB_LEVEL,
  output logic          ERR_OVF,
  input  logic          ERR_CLR
);
  logic [AW-1:0] wb_addr [WB_DEPTH];
  logic [7:0]    wb_strb [WB_DEPTH];
  logic [63:0]   wb_data [WB_DEPTH];
  logic [PW-1:0] head, tail;
  logic [AW-1:0] widx, ridx, addr_q;
  logic [63:0]   wdata_q, fdata, fdata_q, merged;
  logic [7:0]    fmask, fmask_q;
  logic          rd, nonempty, full, drain, direct, push, drop, rd_v1;
  assign widx     = SIF_WR_ADDR[AW+2:3];
  assign ridx     = SIF_RD_ADDR[AW+2:3];
  assign rd       = SIF_RD_EN;
  assign nonempty = WB_LEVEL != '0;
  assign full     = WB_LEVEL == LW'(WB_DEPTH);
  assign drain    = !rd && nonempty;
  assign direct   = !rd && !nonempty && SIF_WR_EN;
  // Once anything is parked, later writes queue behind it to keep FIFO order.
  assign push     = SIF_WR_EN && (rd || nonempty) && !(rd && full);
  assign drop     = SIF_WR_EN && rd && full;
  assign SRAM_CEN   = !(rd || drain || direct);
  assign SRAM_WEN   = !(drain || direct);
  assign SRAM_ADDR  = rd ? ridx : drain ? wb_addr[head] : direct ? widx : addr_q;
  assign SRAM_WMASK = drain ? wb_strb[head] : direct ? SIF_WR_STRB : '0;
  assign SRAM_WDATA = drain ? wb_data[head] : direct ? SIF_WR_DATA : wdata_q;
  // Walk oldest to youngest so younger entries overwrite older bytes.
  always_comb begin
    fmask = '0;
    fdata = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (LW'(i) < WB_LEVEL && wb_addr[head + PW'(i)] == ridx)
        for (int b = 0; b < 8; b++)
          if (wb_strb[head + PW'(i)][b]) begin
            fmask[b] = 1'b1;
            fdata[8*b +: 8] = wb_data[head + PW'(i)][8*b +: 8];
          end
    end
  end
  always_comb begin
    merged = '0;
    for (int b = 0; b < 8; b++)
      merged[8*b +: 8] = fmask_q[b] ? fdata_q[8*b +: 8] : SRAM_RDATA[8*b +: 8];
  end
  always_ff @(posedge ACLK) begin
    if (push) begin
      wb_addr[tail] <= widx;
      wb_strb[tail] <= SIF_WR_STRB;
      wb_data[tail] <= SIF_WR_DATA;
    end
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      head         <= '0;
      tail         <= '0;
      WB_LEVEL     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_v1        <= 1'b0;
      fmask_q      <= '0;
      fdata_q      <= '0;
      SIF_RD_VALID <= 1'b0;
      SIF_RD_DATA  <= '0;
      ERR_OVF      <= 1'b0;
    end else begin
      if (!SRAM_CEN) addr_q <= SRAM_ADDR;
      if (!SRAM_WEN) wdata_q <= SRAM_WDATA;
      if (push) tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      WB_LEVEL <= WB_LEVEL + LW'(push) - LW'(drain);
      rd_v1 <= rd;
      if (rd) begin
        fmask_q <= fmask;
        fdata_q <= fdata;
      end
      SIF_RD_VALID <= rd_v1;
      if (rd_v1) SIF_RD_DATA <= merged;
      ERR_OVF <= drop || (ERR_OVF && !ERR_CLR);
    end
  end
endmodule

// File: tb/tb_aha_sif_sram_bridge.sv
// tb_aha_sif_sram_bridge: random and directed traffic checked cycle by cycle
// against a queue-based model of the bridge plus a flat logical memory image.
module tb_aha_sif_sram_bridge;
  localparam int AW = 10;
  localparam int WD = 4;
  localparam int LW = $clog2(WD) + 1;
  logic          ACLK = 0;
  logic          ARESETn = 0;
  logic [31:0]   SIF_WR_ADDR = 0, SIF_RD_ADDR = 0;
  logic          SIF_WR_EN = 0, SIF_RD_EN = 0, ERR_CLR = 0;
  logic [7:0]    SIF_WR_STRB = 0;
  logic [63:0]   SIF_WR_DATA = 0;
  logic [63:0]   SIF_RD_DATA, SRAM_WDATA;
  logic [63:0]   SRAM_RDATA = 0;
  logic          SIF_RD_VALID, SRAM_CEN, SRAM_WEN, ERR_OVF;
  logic [AW-1:0] SRAM_ADDR;
  logic [7:0]    SRAM_WMASK;
  logic [LW-1:0] WB_LEVEL;
  aha_sif_sram_bridge #(.AW(AW), .WB_DEPTH(WD)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .SIF_WR_ADDR(SIF_WR_ADDR), .SIF_WR_EN(SIF_WR_EN), .SIF_WR_STRB(SIF_WR_STRB), .SIF_WR_DATA(SIF_WR_DATA),
    .SIF_RD_ADDR(SIF_RD_ADDR), .SIF_RD_EN(SIF_RD_EN), .SIF_RD_DATA(SIF_RD_DATA), .SIF_RD_VALID(SIF_RD_VALID),
    .SRAM_CEN(SRAM_CEN), .SRAM_WEN(SRAM_WEN), .SRAM_ADDR(SRAM_ADDR), .SRAM_WMASK(SRAM_WMASK),
    .SRAM_WDATA(SRAM_WDATA), .SRAM_RDATA(SRAM_RDATA),
    .WB_LEVEL(WB_LEVEL), .ERR_OVF(ERR_OVF), .ERR_CLR(ERR_CLR)
  );
  always #5 ACLK = ~ACLK;
  logic [63:0] sram [1024];
  logic loaded = 0;
  always @(posedge ACLK) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) sram[i] <= {32'(i) * 32'h9e3779b9, 32'(i) ^ 32'h5a5a1234};
      loaded <= 1;
    end else if (!SRAM_CEN) begin
      if (!SRAM_WEN) begin
        for (int b = 0; b < 8; b++)
          if (SRAM_WMASK[b]) sram[SRAM_ADDR][8*b +: 8] <= SRAM_WDATA[8*b +: 8];
      end else SRAM_RDATA <= sram[SRAM_ADDR];
    end
  end
  typedef struct packed {logic [AW-1:0] idx; logic [7:0] st; logic [63:0] d;} wr_t;
  wr_t           q[$];
  logic [63:0]   ref_mem [1024];
  logic          p1v, p2v, ovf;
  logic [63:0]   p1d, p2d, hold_d, last_wd;
  logic [AW-1:0] last_addr;
  int tests = 0, errs = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_reset();
    ARESETn = 0;
    SIF_RD_EN = 0; SIF_WR_EN = 0; ERR_CLR = 0;
    #1;
    check("rst_cen", SRAM_CEN, 1);
    check("rst_wen", SRAM_WEN, 1);
    check("rst_addr", SRAM_ADDR, 0);
    check("rst_wmask", SRAM_WMASK, 0);
    check("rst_wdata", SRAM_WDATA, 0);
    check("rst_rdata", SIF_RD_DATA, 0);
    check("rst_level", WB_LEVEL, 0);
    check("rst_ovf", ERR_OVF, 0);
    check("rst_valid", SIF_RD_VALID, 0);
    repeat (2) @(posedge ACLK);
    #1 check("rst_valid_hold", SIF_RD_VALID, 0);
    @(negedge ACLK);
    ARESETn = 1;
    q.delete();
    p1v = 0; p2v = 0; p1d = 0; p2d = 0; hold_d = 0; ovf = 0; last_addr = 0; last_wd = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = sram[i];
    @(posedge ACLK);
    #1;
  endtask
  // One bus cycle: drive, then check outputs and advance the model at the falling edge.
  task automatic cyc(input logic rd, input logic wr, input logic clr, input logic [31:0] ra,
                     input logic [31:0] wa, input logic [7:0] st, input logic [63:0] wd);
    logic [AW-1:0] ri, wi;
    int n0;
    wr_t e;
    SIF_RD_EN = rd; SIF_WR_EN = wr; ERR_CLR = clr;
    SIF_RD_ADDR = ra; SIF_WR_ADDR = wa; SIF_WR_STRB = st; SIF_WR_DATA = wd;
    ri = ra[AW+2:3];
    wi = wa[AW+2:3];
    @(negedge ACLK);
    check("level", WB_LEVEL, 64'(q.size()));
    check("ovf", ERR_OVF, ovf);
    check("valid", SIF_RD_VALID, p2v);
    if (p2v) hold_d = p2d;
    check("rdata", SIF_RD_DATA, hold_d);
    n0 = q.size();
    p2v = p1v; p2d = p1d; p1v = rd;
    if (rd) begin
      check("rd_cen", SRAM_CEN, 0);
      check("rd_wen", SRAM_WEN, 1);
      check("rd_addr", SRAM_ADDR, ri);
      p1d = ref_mem[ri];
      last_addr = ri;
    end else if (n0 > 0) begin
      e = q.pop_front();
      check("drain_cen", SRAM_CEN, 0);
      check("drain_wen", SRAM_WEN, 0);
      check("drain_addr", SRAM_ADDR, e.idx);
      check("drain_wmask", SRAM_WMASK, e.st);
      check("drain_wdata", SRAM_WDATA, e.d);
      last_addr = e.idx; last_wd = e.d;
    end else if (wr) begin
      check("dir_cen", SRAM_CEN, 0);
      check("dir_wen", SRAM_WEN, 0);
      check("dir_addr", SRAM_ADDR, wi);
      check("dir_wmask", SRAM_WMASK, st);
      check("dir_wdata", SRAM_WDATA, wd);
      last_addr = wi; last_wd = wd;
    end else begin
      check("idle_cen", SRAM_CEN, 1);
      check("idle_addr", SRAM_ADDR, last_addr);
      check("idle_wdata", SRAM_WDATA, last_wd);
    end
    if (wr && rd && n0 == WD) ovf = 1;
    else begin
      if (clr) ovf = 0;
      if (wr) begin
        if (rd || n0 > 0) q.push_back('{wi, st, wd});
        for (int b = 0; b < 8; b++) if (st[b]) ref_mem[wi][8*b +: 8] = wd[8*b +: 8];
      end
    end
    @(posedge ACLK);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask
  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[AW+2:3] = AW'($urandom_range(0, 7));
    return a;
  endfunction
  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction
  int pr [4] = '{30, 85, 10, 70};
  int pw [4] = '{30, 85, 70, 20};
  initial begin
    do_reset();
    cyc(0, 1, 0, 0, 32'h08, 8'hFF, 64'h1122334455667788);
    idle(1);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 32'(i * 8), 0, 0, 0);
    idle(3);
    cyc(1, 1, 0, 32'h20, 32'h10, 8'hFF, 64'hAAAAAAAAAAAAAAAA);
    idle(2);
    cyc(0, 1, 0, 0, 32'h10, 8'hFF, 64'h0);
    cyc(1, 1, 0, 32'h40, 32'h10, 8'h03, 64'h123456789ABCCCDD);
    cyc(1, 0, 0, 32'h10, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, rnd_addr(), rnd_addr(), 8'(i + 1), rnd64());
    cyc(1, 0, 0, rnd_addr(), 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(6);
    cyc(1, 1, 0, 32'h18, 32'h28, 8'hFF, rnd64());
    cyc(1, 1, 0, 32'h28, 32'h30, 8'h0F, rnd64());
    cyc(1, 0, 0, 32'h30, 0, 0, 0);
    do_reset();
    idle(2);
    cyc(0, 1, 0, 0, 32'h50, 8'h00, rnd64());
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 600; i++)
        cyc($urandom_range(0, 99) < pr[p], $urandom_range(0, 99) < pw[p], $urandom_range(0, 99) < 5,
            rnd_addr(), rnd_addr(), 8'($urandom), rnd64());
    idle(WD + 4);
    for (int i = 0; i < 1024; i++) check("final_mem", sram[i], ref_mem[i]);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
